// File: rtl/inst_sram_like_responder.sv
// inst_sram_like_responder: SRAM-like req/addr_ok/data_ok responder backed by a word memory, in-order responses after LATENCY cycles
module inst_sram_like_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  input  logic        stall_addr_i,
  input  logic        stall_data_i
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] ent_rd_q [MAX_OUTSTANDING];
  logic [31:0] ent_rd_d [MAX_OUTSTANDING];
  logic [3:0] ent_age_q [MAX_OUTSTANDING];
  logic [3:0] ent_age_d [MAX_OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic [AW-1:0] idx;
  logic accept, pop;
  logic unused_ok;
  assign unused_ok = ^{size_i, addr_i[31:AW+2], addr_i[1:0]};
  assign idx = addr_i[AW+1:2];
  assign addr_ok_o = req_i & ~stall_addr_i & ~reset_i & (count_q < MAXO);
  assign accept = addr_ok_o;
  assign pop = (count_q != 4'd0) & (ent_age_q[head_q] >= LAT) & ~stall_data_i;
  assign data_ok_o = data_ok_q;
  assign rdata_o = rdata_q;
  // Read data is captured from the pre-write memory word; writes queue a zero response.
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      ent_rd_d[i] = (accept && tail_q == PW'(i)) ? (wr_i ? 32'd0 : mem_q[idx]) : ent_rd_q[i];
      ent_age_d[i] = (accept && tail_q == PW'(i)) ? 4'd1 :
                     (ent_age_q[i] >= LAT ? LAT : ent_age_q[i] + 4'd1);
    end
    head_d = pop ? (head_q == LAST ? '0 : head_q + PW'(1)) : head_q;
    tail_d = accept ? (tail_q == LAST ? '0 : tail_q + PW'(1)) : tail_q;
    count_d = count_q + 4'(accept) - 4'(pop);
    data_ok_d = pop;
    rdata_d = pop ? ent_rd_q[head_q] : rdata_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      data_ok_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q <= rdata_d;
    end
  end
  // Memory and queue payload carry no reset so contents survive a reset.
  always_ff @(posedge clk_i) begin
    ent_rd_q <= ent_rd_d;
    ent_age_q <= ent_age_d;
    for (int i = 0; i < 4; i++)
      if (accept && wr_i && wstrb_i[i]) mem_q[idx][8*i+:8] <= wdata_i[8*i+:8];
  end
  logic [31:0] acc_n_q, dok_n_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_n_q <= '0;
      dok_n_q <= '0;
    end else begin
      acc_n_q <= acc_n_q + 32'(accept);
      dok_n_q <= dok_n_q + 32'(data_ok_q);
    end
  end
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(pop && count_q == 4'd0));
  a_count_max: assert property (@(posedge clk_i) disable iff (reset_i) count_q <= MAXO);
  a_dok_le_acc: assert property (@(posedge clk_i) disable iff (reset_i) dok_n_q <= acc_n_q);
endmodule

// File: tb/tb_inst_sram_like_responder.sv
// tb_inst_sram_like_responder: two latencies driven in lockstep, checked every cycle against a timestamp queue model
module tb_inst_sram_like_responder;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, wr = 1'b0, stall_addr = 1'b0, stall_data = 1'b0;
  logic [1:0] size = 2'd2;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] wstrb = '0;
  logic [1:0] aok, dok;
  logic [31:0] rdv [2];
  always #5 clk = ~clk;
  inst_sram_like_responder #(.LATENCY(1)) u_l1 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr),
    .wstrb_i(wstrb), .wdata_i(wdata), .addr_ok_o(aok[0]), .data_ok_o(dok[0]), .rdata_o(rdv[0]),
    .stall_addr_i(stall_addr), .stall_data_i(stall_data));
  inst_sram_like_responder #(.LATENCY(3)) u_l3 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr),
    .wstrb_i(wstrb), .wdata_i(wdata), .addr_ok_o(aok[1]), .data_ok_o(dok[1]), .rdata_o(rdv[1]),
    .stall_addr_i(stall_addr), .stall_data_i(stall_data));
  typedef struct {int rdy; logic [31:0] rd;} rsp_t;
  rsp_t mq [2][$];
  rsp_t mhead;
  logic [31:0] mm [2][1024];
  logic exp_dok [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
  int edge_n = 0, mcnt, n_cmp = 0, n_bad = 0, na0, na1;
  bit macc, mpop, chk_en = 1'b0;
  logic [31:0] mw;
  logic [9:0] midx;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Each accepted request becomes ready LATENCY edges after its accept edge; one release per edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        exp_dok[k] = 1'b0;
        exp_rd[k] = 32'd0;
      end
    end else begin
      edge_n++;
      midx = addr[11:2];
      for (int k = 0; k < 2; k++) begin
        mcnt = mq[k].size();
        macc = req && !stall_addr && mcnt < 4;
        if (mcnt > 0) mhead = mq[k][0];
        mpop = mcnt > 0 && mhead.rdy <= edge_n && !stall_data;
        mw = mm[k][midx];
        exp_dok[k] = mpop;
        if (mpop) begin
          exp_rd[k] = mhead.rd;
          void'(mq[k].pop_front());
        end
        if (macc) begin
          for (int b = 0; b < 4; b++) if (wr && wstrb[b]) mm[k][midx][8*b+:8] = wdata[8*b+:8];
          mq[k].push_back('{edge_n + (k == 0 ? 1 : 3), wr ? 32'd0 : mw});
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) for (int k = 0; k < 2; k++) begin
    chk($sformatf("addr_ok%0d", k), {31'd0, aok[k]}, {31'd0, (req && !stall_addr && !reset && mq[k].size() < 4)});
    chk($sformatf("data_ok%0d", k), {31'd0, dok[k]}, {31'd0, exp_dok[k]});
    chk($sformatf("rdata%0d", k), rdv[k], exp_rd[k]);
  end
  task automatic put(input bit r, input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req = r; wr = w; addr = a; wstrb = s; wdata = d;
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) begin put(1, 1, 32'(i * 4), 4'hF, $urandom); tick(1); end
    put(0, 0, 0, 0, 0);
    tick(8);
    put(1, 1, 32'h40, 4'hF, 32'hDEADBEEF); tick(1); put(0, 0, 0, 0, 0); tick(6);
    put(1, 0, 32'h40, 4'h0, 32'h0);
    @(negedge clk); chk("single_aok", {30'd0, aok}, 32'd3);
    @(posedge clk); #1; put(0, 0, 0, 0, 0);
    @(negedge clk); chk("l1_early", {31'd0, dok[0]}, 32'd0);
    @(negedge clk); chk("l1_dok", {31'd0, dok[0]}, 32'd1); chk("l1_rd", rdv[0], 32'hDEADBEEF);
    @(negedge clk); chk("l1_idle", {31'd0, dok[0]}, 32'd0); chk("l3_early", {31'd0, dok[1]}, 32'd0);
    @(negedge clk); chk("l3_dok", {31'd0, dok[1]}, 32'd1); chk("l3_rd", rdv[1], 32'hDEADBEEF);
    tick(4);
    for (int i = 0; i < 4; i++) begin put(1, 0, 32'(i * 4), 4'h0, 32'h0); tick(1); end
    put(0, 0, 0, 0, 0); tick(8);
    stall_data = 1'b1; na0 = 0; na1 = 0;
    for (int i = 0; i < 6; i++) begin
      put(1, 0, 32'((i + 32) * 4), 4'h0, 32'h0);
      @(negedge clk); na0 += int'(aok[0]); na1 += int'(aok[1]);
      @(posedge clk); #1;
    end
    chk("full_acc_l1", 32'(na0), 32'd4);
    chk("full_acc_l3", 32'(na1), 32'd4);
    stall_data = 1'b0;
    tick(10);
    put(0, 0, 0, 0, 0); tick(10);
    put(1, 1, 32'h80, 4'hF, 32'hAAAAAAAA); tick(1);
    put(1, 1, 32'h80, 4'h3, 32'h12345678); tick(1);
    put(1, 0, 32'h80, 4'h0, 32'h0); tick(1);
    put(0, 0, 0, 0, 0); tick(8);
    chk("wr_rd_l1", rdv[0], 32'hAAAA5678);
    chk("wr_rd_l3", rdv[1], 32'hAAAA5678);
    put(1, 0, 32'h1C001003, 4'h0, 32'h0); tick(1); put(0, 0, 0, 0, 0); tick(8);
    chk("wrap_l1", rdv[0], mm[0][0]);
    chk("wrap_l3", rdv[1], mm[1][0]);
    put(1, 0, 32'h40, 4'h0, 32'h0); tick(3);
    #3 reset = 1'b1;
    #1 chk("rst_aok", {30'd0, aok}, 32'd0); chk("rst_dok", {30'd0, dok}, 32'd0);
    tick(2);
    reset = 1'b0;
    put(0, 0, 0, 0, 0); tick(6);
    put(1, 0, 32'h40, 4'h0, 32'h0); tick(1); put(0, 0, 0, 0, 0); tick(6);
    chk("post_rst_l1", rdv[0], 32'hDEADBEEF);
    chk("post_rst_l3", rdv[1], 32'hDEADBEEF);
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 3) != 0, 1'($urandom),
          ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3),
          4'($urandom), $urandom);
      size = 2'($urandom);
      stall_addr = $urandom_range(0, 7) == 0;
      stall_data = $urandom_range(0, 3) == 0;
      tick(1);
    end
    put(0, 0, 0, 0, 0); stall_addr = 1'b0; stall_data = 1'b0;
    tick(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
